// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int PC_WIDTH       = 8;
    localparam int RAM_ADDR_WIDTH = 16;
    localparam int INSTR_WIDTH    = 32;

    localparam logic [INSTR_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        CAPT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, instruction RAM read port and valid/ready instruction presenter
//
// Ports:
//   Clk, Reset          clock and asynchronous active-low reset
//   Start, Start_pc     one-cycle pulse that begins fetching at Start_pc (IDLE/HALT only)
//   Enable_i, RW_ram_i,
//   Address_in_i, Out_i instruction RAM read port (read data one cycle after address)
//   Instr, Instr_valid,
//   Instr_ready         instruction handshake towards decode
//   Branch_en,
//   Branch_target       redirect request, highest priority while fetching
//   pc                  address of the current / in-flight instruction
//   Halted              fetch stopped by halt word or last address
//   Fetch_count         saturating count of instructions accepted downstream
module instr_fetch_unit #(
    parameter int                              PC_WIDTH  = fetch_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]             LAST_PC   = PC_WIDTH'(15),
    parameter logic [fetch_pkg::INSTR_WIDTH-1:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 Start,
    input  logic [PC_WIDTH-1:0]                  Start_pc,
    output logic                                 Enable_i,
    output logic                                 RW_ram_i,
    output logic [fetch_pkg::RAM_ADDR_WIDTH-1:0] Address_in_i,
    input  logic [fetch_pkg::INSTR_WIDTH-1:0]    Out_i,
    output logic [fetch_pkg::INSTR_WIDTH-1:0]    Instr,
    output logic                                 Instr_valid,
    input  logic                                 Instr_ready,
    input  logic                                 Branch_en,
    input  logic [PC_WIDTH-1:0]                  Branch_target,
    output logic [PC_WIDTH-1:0]                  pc,
    output logic                                 Halted,
    output logic [15:0]                          Fetch_count
);
    import fetch_pkg::*;

    fetch_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic                     valid_q, valid_d;
    logic                     halted_q, halted_d;
    logic                     enable_q, enable_d;
    logic [15:0]              count_q, count_d;

    logic fetching;
    logic take_branch;
    logic handshake;
    logic start_ok;
    logic halt_seen;

    assign fetching    = (state_q == REQ) || (state_q == CAPT) || (state_q == HOLD);
    assign take_branch = fetching && Branch_en;
    assign handshake   = (state_q == HOLD) && Instr_ready;
    assign start_ok    = ((state_q == IDLE) || (state_q == HALT)) && Start;
    assign halt_seen   = (Out_i == HALT_WORD);

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect overrides every fetching transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALT: if (Start) state_d = REQ;
            REQ:        state_d = CAPT;
            CAPT:       state_d = halt_seen ? HALT : HOLD;
            HOLD: begin
                if (Instr_ready) state_d = (pc_q == LAST_PC) ? HALT : REQ;
            end
            default:    state_d = IDLE;
        endcase
        if (take_branch) state_d = REQ;
    end

    // Registered output / datapath next values
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;

        if (start_ok) begin
            pc_d     = Start_pc;
            count_d  = '0;
            halted_d = 1'b0;
        end

        // The handshake is counted even when a redirect lands on the same edge
        if (handshake && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end

        if (take_branch) begin
            pc_d    = Branch_target;
            valid_d = 1'b0;
        end else begin
            if (state_q == CAPT) begin
                if (halt_seen) begin
                    halted_d = 1'b1;
                end else begin
                    instr_d = Out_i;
                    valid_d = 1'b1;
                end
            end
            if (handshake) begin
                valid_d = 1'b0;
                if (pc_q == LAST_PC) begin
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc_q + PC_WIDTH'(1);
                end
            end
        end

        // RAM enable is registered, so it is decoded from the state being entered
        enable_d = (state_d == REQ);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            enable_q <= 1'b0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            enable_q <= enable_d;
            count_q  <= count_d;
        end
    end

    assign Enable_i     = enable_q;
    assign RW_ram_i     = 1'b1;
    assign Address_in_i = {{(RAM_ADDR_WIDTH-PC_WIDTH){1'b0}}, pc_q};
    assign Instr        = instr_q;
    assign Instr_valid  = valid_q;
    assign pc           = pc_q;
    assign Halted       = halted_q;
    assign Fetch_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  Start_pc;
    logic        Enable_i;
    logic        RW_ram_i;
    logic [15:0] Address_in_i;
    logic [31:0] Out_i;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic        Instr_ready;
    logic        Branch_en;
    logic [7:0]  Branch_target;
    logic [7:0]  pc;
    logic        Halted;
    logic [15:0] Fetch_count;

    instr_fetch_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Start_pc     (Start_pc),
        .Enable_i     (Enable_i),
        .RW_ram_i     (RW_ram_i),
        .Address_in_i (Address_in_i),
        .Out_i        (Out_i),
        .Instr        (Instr),
        .Instr_valid  (Instr_valid),
        .Instr_ready  (Instr_ready),
        .Branch_en    (Branch_en),
        .Branch_target(Branch_target),
        .pc           (pc),
        .Halted       (Halted),
        .Fetch_count  (Fetch_count)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [256];

    always @(posedge Clk) begin
        if (Enable_i) Out_i <= mem[Address_in_i[7:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int a);
        return (a < 16) ? (32'h1000_0000 + a) : (32'h2000_0000 + a);
    endfunction

    task automatic fill(input int halt_addr);
        for (int a = 0; a < 256; a++) mem[a] = word_of(a);
        if (halt_addr >= 0) mem[halt_addr] = 32'hFFFF_FFFF;
    endtask

    task automatic do_reset();
        Reset = 1'b0; Start = 1'b0; Start_pc = '0;
        Branch_en = 1'b0; Branch_target = '0; Instr_ready = 1'b1;
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic pulse_start(input logic [7:0] spc);
        Start = 1'b1; Start_pc = spc;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (Instr_valid) begin ok = 1; break; end
            @(negedge Clk);
        end
        if (!ok) chk("wait_valid_timeout", 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic [7:0] start_pc;
        int         halt_addr;
        int         exp_n;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v);
        logic [7:0] exp_pc;
        int n, cyc;
        fill(v.halt_addr);
        Instr_ready = 1'b1;
        pulse_start(v.start_pc);
        chk("start_clears_halted", 32'(Halted), 32'd0);
        chk("first_req_enable", 32'(Enable_i), 32'd1);
        chk("first_req_addr", 32'(Address_in_i), {24'd0, v.start_pc});
        exp_pc = v.start_pc;
        n = 0;
        cyc = 1;
        while (!Halted && cyc < 2000) begin
            if (Instr_valid) begin
                chk("stream_instr", Instr, mem[exp_pc]);
                chk("stream_valid_phase", 32'(cyc % 3), 32'd0);
                exp_pc = exp_pc + 8'd1;
                n++;
            end
            @(negedge Clk);
            cyc++;
        end
        chk("stream_n", 32'(n), 32'(v.exp_n));
        chk("stream_fetch_count", 32'(Fetch_count), 32'(v.exp_n));
        chk("stream_halted", 32'(Halted), 32'd1);
        chk("stream_halt_enable", 32'(Enable_i), 32'd0);
        chk("stream_halt_valid", 32'(Instr_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{start_pc: 8'd0,   halt_addr: -1, exp_n: 16};
        vecs[1] = '{start_pc: 8'd0,   halt_addr: 3,  exp_n: 3};
        vecs[2] = '{start_pc: 8'd12,  halt_addr: -1, exp_n: 4};
        vecs[3] = '{start_pc: 8'hFE,  halt_addr: -1, exp_n: 18};

        fill(-1);
        do_reset();

        chk("rst_enable", 32'(Enable_i), 32'd0);
        chk("rst_rw", 32'(RW_ram_i), 32'd1);
        chk("rst_addr", 32'(Address_in_i), 32'd0);
        chk("rst_instr", Instr, 32'd0);
        chk("rst_valid", 32'(Instr_valid), 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);
        chk("rst_count", 32'(Fetch_count), 32'd0);

        // Branch in IDLE must not start fetching
        Branch_en = 1'b1; Branch_target = 8'd9;
        @(negedge Clk); @(negedge Clk);
        Branch_en = 1'b0;
        chk("idle_branch_enable", 32'(Enable_i), 32'd0);
        chk("idle_branch_pc", 32'(pc), 32'd0);

        // Streams chained: each Start is issued from HALT
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Stall in HOLD for 5 cycles
        fill(-1);
        do_reset();
        Instr_ready = 1'b0;
        pulse_start(8'd0);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("stall_instr", Instr, 32'h1000_0000);
            chk("stall_valid", 32'(Instr_valid), 32'd1);
            chk("stall_pc", 32'(pc), 32'd0);
            chk("stall_enable", 32'(Enable_i), 32'd0);
        end
        Instr_ready = 1'b1;
        @(negedge Clk);
        chk("release_valid", 32'(Instr_valid), 32'd0);
        chk("release_pc", 32'(pc), 32'd1);
        chk("release_enable", 32'(Enable_i), 32'd1);
        chk("release_addr", 32'(Address_in_i), 32'd1);
        chk("release_count", 32'(Fetch_count), 32'd1);

        // Branch during CAPT of address 2
        do_reset();
        pulse_start(8'd0);
        for (int i = 0; i < 50; i++) begin
            if (Enable_i && Address_in_i == 16'd2) break;
            @(negedge Clk);
        end
        chk("reach_req2", 32'(Address_in_i), 32'd2);
        @(negedge Clk);
        Branch_en = 1'b1; Branch_target = 8'd10;
        @(negedge Clk);
        Branch_en = 1'b0;
        chk("capt_br_enable", 32'(Enable_i), 32'd1);
        chk("capt_br_addr", 32'(Address_in_i), 32'd10);
        chk("capt_br_valid", 32'(Instr_valid), 32'd0);
        wait_valid(20);
        chk("capt_br_instr", Instr, 32'h1000_000A);
        chk("capt_br_pc", 32'(pc), 32'd10);
        chk("capt_br_count", 32'(Fetch_count), 32'd2);

        // Branch together with handshake in HOLD at pc=4
        do_reset();
        pulse_start(8'd0);
        for (int i = 0; i < 100; i++) begin
            if (Instr_valid && pc == 8'd4) break;
            @(negedge Clk);
        end
        chk("reach_hold4", 32'(pc), 32'd4);
        chk("hold4_count", 32'(Fetch_count), 32'd4);
        Branch_en = 1'b1; Branch_target = 8'd1;
        @(negedge Clk);
        Branch_en = 1'b0;
        chk("hold_br_count", 32'(Fetch_count), 32'd5);
        chk("hold_br_addr", 32'(Address_in_i), 32'd1);
        chk("hold_br_enable", 32'(Enable_i), 32'd1);
        chk("hold_br_valid", 32'(Instr_valid), 32'd0);
        wait_valid(20);
        chk("hold_br_instr", Instr, 32'h1000_0001);

        // Reset asserted during CAPT
        do_reset();
        pulse_start(8'd5);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_enable", 32'(Enable_i), 32'd0);
        chk("mid_rst_rw", 32'(RW_ram_i), 32'd1);
        chk("mid_rst_addr", 32'(Address_in_i), 32'd0);
        chk("mid_rst_instr", Instr, 32'd0);
        chk("mid_rst_valid", 32'(Instr_valid), 32'd0);
        chk("mid_rst_count", 32'(Fetch_count), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("post_rst_idle", 32'(Enable_i), 32'd0);
        chk("post_rst_valid", 32'(Instr_valid), 32'd0);
        pulse_start(8'd5);
        wait_valid(20);
        chk("refetch_instr", Instr, 32'h1000_0005);
        chk("refetch_pc", 32'(pc), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
